// File: rtl/dtl_slave_memory.sv
// -----------------------------------------------------------------------------
// dtl_slave_memory
//
// Single-beat DTL slave wrapped around a synchronous, word-addressed RAM.
// It terminates the command, write and read channels of a DTL master and
// handles one transaction at a time. WAIT_CYCLES inserts wait states between
// command accept and the data phase so that a master's busy and postponed-read
// paths get exercised.
//
// Ports:
//   iClk                  clock
//   iReset                synchronous active-high reset (RAM is not cleared)
//   iDTL_CommandValid     command request
//   iDTL_CommandReadWrite 1 = read, 0 = write
//   iDTL_Address          byte address; word index is taken from the bits
//                         just above the byte-lane bits, so addresses wrap
//                         modulo the RAM size
//   iDTL_BlockSize        ignored (always a single beat)
//   iDTL_WriteValid       write data valid
//   iDTL_WriteData        write data
//   iDTL_WriteEnable      byte enables
//   iDTL_WriteLast        ignored
//   iDTL_ReadAccept       master accepts read data
//   oDTL_CommandAccept    high whenever the slave is idle
//   oDTL_WriteAccept      one-cycle pulse when write data is taken
//   oDTL_ReadValid        read data valid (held until accepted)
//   oDTL_ReadLast         constant 1
//   oDTL_ReadData         registered RAM output
// -----------------------------------------------------------------------------
module dtl_slave_memory #(
    parameter int INTERFACE_WIDTH       = 32,
    parameter int INTERFACE_ADDR_WIDTH  = 32,
    parameter int INTERFACE_BLOCK_WIDTH = 5,
    parameter int NUM_ENABLES           = INTERFACE_WIDTH / 8,
    parameter int DEPTH_LOG2            = 10,
    parameter int WAIT_CYCLES           = 0
) (
    input  logic                             iClk,
    input  logic                             iReset,
    input  logic                             iDTL_CommandValid,
    input  logic                             iDTL_CommandReadWrite,
    input  logic [INTERFACE_ADDR_WIDTH-1:0]  iDTL_Address,
    input  logic [INTERFACE_BLOCK_WIDTH-1:0] iDTL_BlockSize,
    input  logic                             iDTL_WriteValid,
    input  logic [INTERFACE_WIDTH-1:0]       iDTL_WriteData,
    input  logic [NUM_ENABLES-1:0]           iDTL_WriteEnable,
    input  logic                             iDTL_WriteLast,
    input  logic                             iDTL_ReadAccept,
    output logic                             oDTL_CommandAccept,
    output logic                             oDTL_WriteAccept,
    output logic                             oDTL_ReadValid,
    output logic                             oDTL_ReadLast,
    output logic [INTERFACE_WIDTH-1:0]       oDTL_ReadData
);

    localparam int ADDR_LSB = $clog2(NUM_ENABLES);
    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [7:0] WAIT_LOAD = 8'(WAIT_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        WRITE,
        RDMEM,
        RESP
    } state_t;

    state_t                stateReg;
    logic [7:0]            waitCountReg;
    logic [DEPTH_LOG2-1:0] indexReg;
    logic                  isReadReg;
    logic                  writeFire;

    // Block size, write-last and the address bits outside the word index
    // carry no meaning for a single-beat slave.
    logic unusedInputs;
    assign unusedInputs = ^{iDTL_BlockSize, iDTL_WriteLast, iDTL_Address};

    // A reset in the write-accept cycle must neither write RAM nor signal
    // acceptance, so reset is folded into the write strobe.
    assign writeFire          = (stateReg == WRITE) && iDTL_WriteValid && !iReset;
    assign oDTL_CommandAccept = (stateReg == IDLE);
    assign oDTL_WriteAccept   = writeFire;
    assign oDTL_ReadValid     = (stateReg == RESP);
    assign oDTL_ReadLast      = 1'b1;

    always_ff @(posedge iClk) begin
        if (iReset) begin
            stateReg     <= IDLE;
            waitCountReg <= 8'd0;
            indexReg     <= '0;
            isReadReg    <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (iDTL_CommandValid) begin
                        indexReg  <= iDTL_Address[ADDR_LSB +: DEPTH_LOG2];
                        isReadReg <= iDTL_CommandReadWrite;
                        if (WAIT_CYCLES > 0) begin
                            waitCountReg <= WAIT_LOAD;
                            stateReg     <= WAIT;
                        end else begin
                            stateReg <= iDTL_CommandReadWrite ? RDMEM : WRITE;
                        end
                    end
                end
                WAIT: begin
                    // Leaving on a count of 1 makes the WAIT state last
                    // exactly WAIT_CYCLES cycles.
                    waitCountReg <= waitCountReg - 8'd1;
                    if (waitCountReg == 8'd1) begin
                        stateReg <= isReadReg ? RDMEM : WRITE;
                    end
                end
                WRITE: begin
                    if (iDTL_WriteValid) begin
                        stateReg <= IDLE;
                    end
                end
                RDMEM: begin
                    stateReg <= RESP;
                end
                RESP: begin
                    if (iDTL_ReadAccept) begin
                        stateReg <= IDLE;
                    end
                end
                default: begin
                    stateReg <= IDLE;
                end
            endcase
        end
    end

    // One RAM per byte lane: each lane has its own write enable and its own
    // registered read port, which maps directly onto byte-wide block RAM.
    generate
        for (genvar gi = 0; gi < NUM_ENABLES; gi++) begin : gLane
            logic [7:0] laneMem [0:DEPTH-1];
            logic [7:0] laneReadReg;

            always_ff @(posedge iClk) begin
                if (writeFire && iDTL_WriteEnable[gi]) begin
                    laneMem[indexReg] <= iDTL_WriteData[gi*8 +: 8];
                end
                if (iReset) begin
                    laneReadReg <= 8'd0;
                end else if (stateReg == RDMEM) begin
                    laneReadReg <= laneMem[indexReg];
                end
            end

            assign oDTL_ReadData[gi*8 +: 8] = laneReadReg;
        end
    endgenerate

endmodule

// File: tb/tb_dtl_slave_memory.sv
// -----------------------------------------------------------------------------
// Testbench for dtl_slave_memory. Two instances: dut0 with no wait states
// (table-driven write/read vectors, partial writes, address wrap, held read
// response, reset during WRITE) and dut3 with three wait states (latency and
// command blocking). Inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_dtl_slave_memory;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    // dut0 (WAIT_CYCLES = 0)
    logic        cv, rw, wv, wl, ra;
    logic [31:0] addr, wd;
    logic [4:0]  bs;
    logic [3:0]  we;
    logic        ca, wa, rv, rl;
    logic [31:0] rd;

    // dut3 (WAIT_CYCLES = 3)
    logic        wcv, wrw, wwv, wwl, wra;
    logic [31:0] waddr, wwd;
    logic [4:0]  wbs;
    logic [3:0]  wwe;
    logic        wca, wwa, wrv, wrl;
    logic [31:0] wrd;

    int checks = 0;
    int errors = 0;

    dtl_slave_memory #(.WAIT_CYCLES(0)) dut0 (
        .iClk(clk), .iReset(rst),
        .iDTL_CommandValid(cv), .iDTL_CommandReadWrite(rw),
        .iDTL_Address(addr), .iDTL_BlockSize(bs),
        .iDTL_WriteValid(wv), .iDTL_WriteData(wd), .iDTL_WriteEnable(we),
        .iDTL_WriteLast(wl), .iDTL_ReadAccept(ra),
        .oDTL_CommandAccept(ca), .oDTL_WriteAccept(wa),
        .oDTL_ReadValid(rv), .oDTL_ReadLast(rl), .oDTL_ReadData(rd)
    );

    dtl_slave_memory #(.WAIT_CYCLES(3)) dut3 (
        .iClk(clk), .iReset(rst),
        .iDTL_CommandValid(wcv), .iDTL_CommandReadWrite(wrw),
        .iDTL_Address(waddr), .iDTL_BlockSize(wbs),
        .iDTL_WriteValid(wwv), .iDTL_WriteData(wwd), .iDTL_WriteEnable(wwe),
        .iDTL_WriteLast(wwl), .iDTL_ReadAccept(wra),
        .oDTL_CommandAccept(wca), .oDTL_WriteAccept(wwa),
        .oDTL_ReadValid(wrv), .oDTL_ReadLast(wrl), .oDTL_ReadData(wrd)
    );

    typedef struct {
        bit          isRead;
        logic [31:0] address;
        logic [31:0] data;
        logic [3:0]  enables;
        logic [4:0]  blockSize;
        int          hold;      // cycles with ReadAccept low in RESP
        logic [31:0] expected;  // expected read data
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write with data presented together with the command (WAIT_CYCLES = 0).
    task automatic doWrite(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] e, input logic [4:0] b);
        cv = 1'b1; rw = 1'b0; addr = a; bs = b;
        wv = 1'b1; wd = d; we = e;
        @(negedge clk);
        check("wr_cmd_accept", 32'(ca), 32'd1);
        check("wr_no_early_accept", 32'(wa), 32'd0);
        check("wr_idle_no_rvalid", 32'(rv), 32'd0);
        tick();
        cv = 1'b0;
        @(negedge clk);
        check("wr_accept_T+1", 32'(wa), 32'd1);
        check("wr_busy_no_cmd", 32'(ca), 32'd0);
        tick();
        wv = 1'b0; wd = '0; we = '0;
    endtask

    task automatic doRead(input logic [31:0] a, input logic [4:0] b,
                          input int hold, input logic [31:0] exp);
        cv = 1'b1; rw = 1'b1; addr = a; bs = b; ra = 1'b1;
        @(negedge clk);
        check("rd_cmd_accept", 32'(ca), 32'd1);
        check("rd_idle_no_rvalid", 32'(rv), 32'd0);
        tick();
        cv = 1'b0;
        @(negedge clk);
        check("rd_no_rvalid_T+1", 32'(rv), 32'd0);
        check("rd_busy_no_cmd", 32'(ca), 32'd0);
        tick();
        for (int i = 0; i < hold; i++) begin
            ra = 1'b0;
            @(negedge clk);
            check("rd_hold_rvalid", 32'(rv), 32'd1);
            check("rd_hold_data", rd, exp);
            tick();
        end
        ra = 1'b1;
        @(negedge clk);
        check("rd_rvalid_T+2", 32'(rv), 32'd1);
        check("rd_data", rd, exp);
        check("rd_last", 32'(rl), 32'd1);
        tick();
    endtask

    initial begin
        // word 0x10 -> index 4; 0x1010 wraps onto the same index
        vecs[0]  = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 5'd0, 0, 32'h0};
        vecs[1]  = '{1'b1, 32'h0000_0010, 32'h0,         4'h0, 5'd0, 0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 32'h0000_0010, 32'h0000_00AA, 4'h1, 5'd0, 0, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0010, 32'h0,         4'h0, 5'd0, 0, 32'hDEAD_BEAA};
        vecs[4]  = '{1'b0, 32'h0000_0020, 32'h1234_5678, 4'hF, 5'd0, 0, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0020, 32'h0000_CD00, 4'h2, 5'd0, 0, 32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0020, 32'h0,         4'h0, 5'd0, 4, 32'h1234_CD78};
        vecs[7]  = '{1'b0, 32'h0000_1010, 32'hCAFE_F00D, 4'hF, 5'd0, 0, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_0010, 32'h0,         4'h0, 5'd0, 0, 32'hCAFE_F00D};
        vecs[9]  = '{1'b0, 32'h0000_0044, 32'hA5A5_A5A5, 4'hF, 5'd7, 0, 32'h0};
        vecs[10] = '{1'b0, 32'h0000_0047, 32'h1122_3344, 4'hC, 5'd0, 0, 32'h0};
        vecs[11] = '{1'b1, 32'h0000_0045, 32'h0,         4'h0, 5'd3, 1, 32'h1122_A5A5};

        rst = 1'b1;
        cv = 0; rw = 0; wv = 0; wl = 0; ra = 0; addr = 0; wd = 0; bs = 0; we = 0;
        wcv = 0; wrw = 0; wwv = 0; wwl = 0; wra = 0; waddr = 0; wwd = 0; wbs = 0; wwe = 0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_cmd_accept", 32'(ca), 32'd1);
        check("rst_rvalid", 32'(rv), 32'd0);
        check("rst_waccept", 32'(wa), 32'd0);
        check("rst_rdata", rd, 32'd0);
        check("rst_rlast", 32'(rl), 32'd1);
        check("rst3_cmd_accept", 32'(wca), 32'd1);
        check("rst3_rvalid", 32'(wrv), 32'd0);
        check("rst3_rdata", wrd, 32'd0);
        tick();

        // Three wait states: write accepted at T+4
        wcv = 1'b1; wrw = 1'b0; waddr = 32'h20; wwv = 1'b1; wwd = 32'h600D_F00D; wwe = 4'hF;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("w3_wr_cmd_accept", 32'(wca), 32'(c == 0));
            check("w3_wr_accept", 32'(wwa), 32'(c == 4));
            tick();
            wcv = 1'b0;
        end
        wwv = 1'b0;
        $display("txn w3 write addr=%h data=%h", 32'h20, 32'h600D_F00D);

        // Three wait states: ReadValid at T+5, a second command held meanwhile
        wcv = 1'b1; wrw = 1'b1; waddr = 32'h20; wra = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("w3_rd_cmd_accept", 32'(wca), 32'(c == 0));
            check("w3_rd_rvalid", 32'(wrv), 32'(c == 5));
            if (c == 5) check("w3_rd_data", wrd, 32'h600D_F00D);
            tick();
        end
        @(negedge clk);
        check("w3_rd_idle_accept", 32'(wca), 32'd1);
        check("w3_rd_rvalid_drop", 32'(wrv), 32'd0);
        wcv = 1'b0;
        tick();
        $display("txn w3 read addr=%h expect=%h", 32'h20, 32'h600D_F00D);

        // Table of back-to-back transactions on dut0
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].isRead)
                doRead(vecs[i].address, vecs[i].blockSize, vecs[i].hold, vecs[i].expected);
            else
                doWrite(vecs[i].address, vecs[i].data, vecs[i].enables, vecs[i].blockSize);
            $display("txn %0d %s addr=%h data=%h en=%h expect=%h", i,
                     vecs[i].isRead ? "read " : "write", vecs[i].address,
                     vecs[i].data, vecs[i].enables, vecs[i].expected);
        end

        // Command blocked in WRITE, then reset in the write-accept cycle
        cv = 1'b1; rw = 1'b0; addr = 32'h10; wv = 1'b0;
        @(negedge clk);
        check("rst_wr_cmd_accept", 32'(ca), 32'd1);
        tick();
        @(negedge clk);
        check("write_state_blocks_cmd", 32'(ca), 32'd0);
        check("write_state_waits", 32'(wa), 32'd0);
        tick();
        cv = 1'b0; wv = 1'b1; wd = 32'hFFFF_FFFF; we = 4'hF; rst = 1'b1;
        @(negedge clk);
        check("rst_suppresses_waccept", 32'(wa), 32'd0);
        tick();
        rst = 1'b0; wv = 1'b0; we = 4'h0;
        @(negedge clk);
        check("post_rst_cmd_accept", 32'(ca), 32'd1);
        check("post_rst_rvalid", 32'(rv), 32'd0);
        tick();
        doRead(32'h10, 5'd0, 0, 32'hCAFE_F00D);
        $display("txn reset-in-write addr=%h expect=%h", 32'h10, 32'hCAFE_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dtl_slave_memory.md
Name: dtl_slave_memory

Overview:
- Single-beat DTL slave that wraps a synchronous word-addressed RAM.
- Sits directly downstream of the CGRA DTL master interface and terminates its command, write and read channels; used as the local data/instruction memory model in simulation and small FPGA builds.
- Handles one transaction at a time, with a programmable number of wait states so the master's busy/postponed-read paths get exercised.

Parameters:
- INTERFACE_WIDTH, 32, data bus width in bits; multiple of 8.
- INTERFACE_ADDR_WIDTH, 32, byte address width.
- INTERFACE_BLOCK_WIDTH, 5, block-size field width; field is ignored.
- NUM_ENABLES, INTERFACE_WIDTH/8, byte write enables.
- DEPTH_LOG2, 10, log2 of RAM depth in words.
- WAIT_CYCLES, 0, wait states between command accept and data phase (0..255).

Ports:
- iClk  in  1  clock
- iReset  in  1  synchronous active-high reset
- iDTL_CommandValid  in  1  command request
- iDTL_CommandReadWrite  in  1  1 = read, 0 = write
- iDTL_Address  in  INTERFACE_ADDR_WIDTH  byte address
- iDTL_BlockSize  in  INTERFACE_BLOCK_WIDTH  ignored (single beat only)
- iDTL_WriteValid  in  1  write data valid
- iDTL_WriteData  in  INTERFACE_WIDTH  write data
- iDTL_WriteEnable  in  NUM_ENABLES  byte enables
- iDTL_WriteLast  in  1  ignored
- iDTL_ReadAccept  in  1  master accepts read data
- oDTL_CommandAccept  out  1  command accepted
- oDTL_WriteAccept  out  1  write data accepted (1-cycle pulse)
- oDTL_ReadValid  out  1  read data valid
- oDTL_ReadLast  out  1  constant 1
- oDTL_ReadData  out  INTERFACE_WIDTH  read data

Behaviour:
- Clocking and reset: one clock iClk. Reset is synchronous, active-high on iReset, sampled at posedge.
- Reset state: FSM = IDLE, wait counter = 0, oDTL_ReadValid = 0, oDTL_ReadData = 0, oDTL_WriteAccept = 0. RAM contents are NOT cleared.
- Word index: iDTL_Address[ADDR_LSB +: DEPTH_LOG2], where ADDR_LSB = log2(NUM_ENABLES). Upper address bits and low byte bits are ignored, so addresses wrap modulo the RAM size.
- FSM states: IDLE, WAIT, WRITE, RDMEM, RESP.

IDLE:
- oDTL_CommandAccept = 1, decoded from state; no other condition.
- On iDTL_CommandValid: latch the index and the read/write flag.
- Next state: WAIT if WAIT_CYCLES > 0 (counter loaded with WAIT_CYCLES); otherwise WRITE (write) or RDMEM (read).

WAIT:
- Counter decrements each cycle.
- When the counter reaches 1, go to WRITE or RDMEM.
- Total added latency is exactly WAIT_CYCLES cycles.

WRITE:
- oDTL_WriteAccept = iDTL_WriteValid (combinational AND with state).
- When iDTL_WriteValid = 1: RAM bytes with enable = 1 are written in this cycle; masked bytes keep their old value. Next state IDLE.
- Otherwise stay in WRITE indefinitely.
- Write data that arrives before command acceptance is held by the master; the slave never samples data outside WRITE.

RDMEM:
- Synchronous RAM read of the latched index. Next state RESP.

RESP:
- oDTL_ReadValid = 1, oDTL_ReadData = registered RAM output, held stable.
- When iDTL_ReadAccept = 1, next state IDLE (ReadValid drops next cycle). Otherwise hold.

Latency (WAIT_CYCLES = 0, accept cycle = T):
- Write: WriteAccept at T+1.
- Read: ReadValid at T+2.
- Back-to-back: the next command can be accepted in the cycle after WriteAccept, or after the ReadValid/ReadAccept cycle.

Boundary and special cases:
- Simultaneous CommandValid and WriteValid in IDLE: the command is accepted; the write completes the next cycle (or after the wait states).
- A command arriving while not in IDLE is not accepted (CommandAccept = 0); the master must hold it.
- Read-after-write to the same address returns the new data, since the write commits before IDLE is re-entered.
- A nonzero iDTL_BlockSize is treated as a single beat; oDTL_ReadLast is always 1.
- iReset asserted mid-transaction: the FSM aborts to IDLE next cycle with no RAM write. If reset coincides with a WRITE accept cycle, the write is suppressed and WriteAccept is not asserted.

Test Plan:
1. Reset, then write 0xDEADBEEF to addr 0x10 (enables 4'hF), then read 0x10 (WAIT_CYCLES = 0) -> CommandAccept at T, WriteAccept at T+1; read returns ReadValid at T+2 with data 0xDEADBEEF and ReadLast = 1.
2. Partial write 0x000000AA with enables 4'b0001 to 0x10 -> subsequent read returns 0xDEADBEAA.
3. WAIT_CYCLES = 3, read 0x20 -> ReadValid exactly 5 cycles after the accept cycle; CommandAccept stays 0 for a second command presented meanwhile until the response completes.
4. Hold iDTL_ReadAccept = 0 for 4 cycles during RESP -> ReadValid and data stay constant for 4 cycles and drop one cycle after ReadAccept rises.
5. Write to 0x0000_1010 with DEPTH_LOG2 = 10 -> read of 0x10 returns the same data (address wrap). Master-interface pattern of write followed by immediate postponed read -> read returns the freshly written value.
6. Assert iReset in WRITE state with WriteValid = 1 -> no WriteAccept pulse, RAM word unchanged on a later read, FSM in IDLE with CommandAccept = 1 the cycle after reset deasserts.
